// File: rtl/ps2_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_pkg : shared state type, frame layout constants and frame builder
// Revision: 1.0
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [3:0] BIT_START  = 4'd0;
  localparam logic [3:0] BIT_PARITY = 4'd9;
  localparam logic [3:0] BIT_STOP   = 4'd10;

  // Bit i of the result is the i-th bit on the wire.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    logic [PS2_FRAME_BITS-1:0] f;
    f             = '0;
    f[8:1]        = b;
    f[BIT_START]  = 1'b0;
    f[BIT_PARITY] = ~^b;
    f[BIT_STOP]   = 1'b1;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_tx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_tx_fifo : synchronous FIFO with registered full/empty flags
// Revision: 1.0
// ---------------------------------------------------------------------------
module ps2_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    full_d   = (count_d == (AW+1)'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule
`default_nettype wire

// File: rtl/ps2_device_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_device_tx : PS/2 device-to-host byte transmitter (11-bit odd-parity
// frames). Define PS2_TX_FIFO_EN for an input FIFO instead of one register.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       host_inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  localparam int              PH_W    = $clog2(2 * CLK_DIV);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);

  ps2_state_e                state_q, state_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic [PH_W-1:0]           phase_q, phase_d;
  logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
  logic                      ps2_clk_q, ps2_clk_d;
  logic                      ps2_data_q, ps2_data_d;
  logic                      accept;
  logic                      byte_avail;
  logic                      launch;
  logic                      start;
  logic                      frame_done;
  logic [7:0]                next_byte;

  assign accept = in_valid && in_ready;
  assign launch = byte_avail && !host_inhibit;

`ifdef PS2_TX_FIFO_EN
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;

  // The byte stays at the FIFO head until its frame completes, so an
  // aborted frame can be restarted from the same entry.
  ps2_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (in_data),
    .pop       (frame_done),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready   = !fifo_full;
  assign byte_avail = !fifo_empty || accept;
  assign next_byte  = fifo_empty ? in_data : fifo_head;
`else
  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;
  logic       unused_fifo_depth;

  assign unused_fifo_depth = (FIFO_DEPTH != 0);
  assign in_ready   = (state_q == ST_IDLE) && !hold_valid_q;
  assign byte_avail = hold_valid_q || accept;
  assign next_byte  = hold_valid_q ? hold_q : in_data;

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (accept) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
    end else if (frame_done) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    phase_d    = phase_q;
    frame_d    = frame_q;
    ps2_clk_d  = 1'b1;
    ps2_data_d = 1'b1;
    frame_done = 1'b0;
    start      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        start = launch;
      end
      ST_SEND: begin
        if (host_inhibit && (bit_cnt_q != BIT_STOP)) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          phase_d   = '0;
        end else if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (bit_cnt_q == BIT_STOP) begin
            state_d    = ST_GAP;
            bit_cnt_d  = '0;
            frame_done = 1'b1;
          end else begin
            bit_cnt_d  = bit_cnt_q + 4'd1;
            ps2_data_d = frame_q[bit_cnt_d];
          end
        end else begin
          phase_d    = phase_q + PH_W'(1);
          ps2_clk_d  = (phase_d < PH_HALF);
          ps2_data_d = frame_q[bit_cnt_q];
        end
      end
      ST_GAP: begin
        // A queued byte starts straight out of GAP so back-to-back frames
        // are separated by exactly the gap time.
        if (phase_q == PH_LAST) begin
          state_d = ST_IDLE;
          phase_d = '0;
          start   = launch;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
        phase_d   = '0;
      end
    endcase

    if (start) begin
      state_d    = ST_SEND;
      bit_cnt_d  = BIT_START;
      phase_d    = '0;
      frame_d    = ps2_frame(next_byte);
      ps2_data_d = frame_d[BIT_START];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      phase_q    <= '0;
      frame_q    <= '0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      phase_q    <= phase_d;
      frame_q    <= frame_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
    end
  end

  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_device_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ps2_device_tx : randomized bench for ps2_device_tx against a frame-level
// reference model. Revision: 1.0
// ---------------------------------------------------------------------------
module tb_ps2_device_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int BIT_CYC    = 2 * CLK_DIV;
  localparam int SEND_CYC   = 11 * BIT_CYC;
  localparam int FRAME_CYC  = 24 * CLK_DIV;

  localparam int EV_NONE  = 0;
  localparam int EV_ABORT = 1;
  localparam int EV_LATE  = 2;
  localparam int EV_RST   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       host_inhibit = 1'b0;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  fill_q[$];
  logic [10:0] rx_last = '0;
  logic        saw_drop = 1'b0;

  always #5 clk = ~clk;

  ps2_device_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .host_inhibit (host_inhibit),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t got=%0h required=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wire order: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    int          ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = ((ones % 2) == 0);
    f[10]  = 1'b1;
    return f;
  endfunction

  // {busy, ps2_clk, ps2_data} expected k cycles after the start bit appears.
  function automatic logic [2:0] exp_lines(input logic [10:0] f, input int k);
    if (k < SEND_CYC) return {1'b1, ((k % BIT_CYC) < CLK_DIV), f[k / BIT_CYC]};
    return 3'b111;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      chk("idle", {busy, ps2_clk, ps2_data}, 3'b011);
    end
  endtask

  task automatic launch(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    chk("rdy_launch", in_ready, 1'b1);
    if (in_ready) exp_q.push_back(b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_frames(input int ev_in, input int ev_k);
    logic [7:0]  b;
    logic [10:0] f;
    logic [10:0] rx;
    logic        prev_clk;
    int          falls;
    int          last_fall;
    int          ev;
    bit          interrupted;
    ev = ev_in;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      f = ref_frame(b);
      rx = '0;
      prev_clk = 1'b1;
      falls = 0;
      last_fall = 0;
      interrupted = 1'b0;
      for (int k = 0; k < FRAME_CYC; k++) begin
        chk("lines", {busy, ps2_clk, ps2_data}, exp_lines(f, k));
`ifndef PS2_TX_FIFO_EN
        chk("rdy_busy", in_ready, 1'b0);
`endif
        if (prev_clk && !ps2_clk) begin
          if (falls > 0) chk("fall_gap", k - last_fall, BIT_CYC);
          if (falls < 11) rx[falls] = ps2_data;
          last_fall = k;
          falls++;
        end
        prev_clk = ps2_clk;
`ifdef PS2_TX_FIFO_EN
        if (fill_q.size() > 0) begin
          in_valid = 1'b1;
          in_data  = fill_q.pop_front();
        end else begin
          in_valid = 1'b0;
        end
`else
        in_valid = (k < 80) && ($urandom_range(0, 1) == 1);
        in_data  = 8'($urandom);
`endif
        if (ev == EV_ABORT && k == ev_k) begin
          in_valid     = 1'b0;
          host_inhibit = 1'b1;
          tick();
          chk("abort_lines", {busy, ps2_clk, ps2_data}, 3'b011);
          repeat ($urandom_range(2, 12)) begin
            tick();
            chk("inh_lines", {busy, ps2_clk, ps2_data}, 3'b011);
`ifndef PS2_TX_FIFO_EN
            chk("inh_rdy", in_ready, 1'b0);
`endif
          end
          host_inhibit = 1'b0;
          tick();
          exp_q.push_front(b);
          ev = EV_NONE;
          interrupted = 1'b1;
          break;
        end
        if (ev == EV_RST && k == ev_k) begin
          in_valid = 1'b0;
          rst = 1'b1;
          tick();
          chk("rst_lines", {busy, ps2_clk, ps2_data}, 3'b011);
          rst = 1'b0;
          chk("rst_rdy", in_ready, 1'b1);
          exp_q.delete();
          interrupted = 1'b1;
          break;
        end
        if (ev == EV_LATE) host_inhibit = (k >= ev_k) && (k < FRAME_CYC - 1);
        if (in_valid && in_ready) exp_q.push_back(in_data);
        if (in_valid && !in_ready) saw_drop = 1'b1;
        tick();
      end
      if (!interrupted) begin
        chk("falls", falls, 11);
        chk("rx_frame", rx, f);
        rx_last = rx;
      end
    end
    in_valid = 1'b0;
    chk("idle_after", {busy, ps2_clk, ps2_data, in_ready}, 4'b0111);
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_lines", {busy, ps2_clk, ps2_data}, 3'b011);
    rst = 1'b0;
    chk("reset_rdy", in_ready, 1'b1);

    launch(8'h1C);
    run_frames(EV_NONE, 0);
    chk("rx_1c", rx_last, 11'b100_0011_1000);

    idle(2);
    launch(8'h00);
    run_frames(EV_NONE, 0);
    chk("par_00", rx_last[9], 1'b1);
    launch(8'hFF);
    run_frames(EV_NONE, 0);
    chk("par_ff", rx_last[9], 1'b1);
    launch(8'h01);
    run_frames(EV_NONE, 0);
    chk("par_01", rx_last[9], 1'b0);

    repeat (6) begin
      idle($urandom_range(0, 5));
      launch(8'($urandom));
      run_frames(EV_NONE, 0);
    end

    // Inhibit during data bit 4, then during stop bit and gap.
    launch(8'($urandom));
    run_frames(EV_ABORT, 42);
    idle(2);
    launch(8'($urandom));
    run_frames(EV_LATE, 82);

    // Reset during data bit 6; the byte must not reappear.
    idle(1);
    launch(8'($urandom));
    run_frames(EV_RST, 58);
    idle(5);
    launch(8'($urandom));
    run_frames(EV_NONE, 0);

`ifdef PS2_TX_FIFO_EN
    idle(2);
    fill_q.push_back(8'h1C);
    launch(8'hF0);
    run_frames(EV_NONE, 0);
    idle(2);
    saw_drop = 1'b0;
    repeat (9) fill_q.push_back(8'($urandom));
    launch(8'($urandom));
    run_frames(EV_NONE, 0);
    chk("full_drop", saw_drop, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
